// File: rtl/controle_registrador_7bits.sv
// Sequencer for an external 7-bit universal shift register: one parallel load,
// then N shift/rotate cycles while collecting the register's last-stage bit.
module controle_registrador_7bits #(
  parameter int PASSOS_MAX = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       aborta,
  input  logic       modo,
  input  logic [2:0] n_passos,
  input  logic [6:0] dado,
  input  logic       serial_in,
  input  logic       saida_ultimoflip,
  output logic       ch1,
  output logic       ch0,
  output logic [6:0] bits,
  output logic       d,
  output logic       busy,
  output logic       done,
  output logic [6:0] capturada
);

  typedef enum logic [1:0] {OCIOSO, CARGA, DESLOCA, FIM} state_t;

  typedef struct packed {
    logic [1:0] ch;
    logic [6:0] bits;
    logic       d;
    logic       busy;
    logic       done;
    logic [6:0] capturada;
  } saida_t;

  localparam logic [2:0] CNT_MAX = 3'(PASSOS_MAX);

  state_t     state, state_nxt;
  saida_t     out_q, out_nxt;
  logic [2:0] cnt, cnt_nxt;
  logic       modo_q, modo_nxt;
  logic       inicia;

  // aborta outranks start while idle
  assign inicia = (state == OCIOSO) && start && !aborta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= OCIOSO;
      cnt    <= 3'd0;
      modo_q <= 1'b0;
      out_q  <= '0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      modo_q <= modo_nxt;
      out_q  <= out_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      OCIOSO:  if (inicia) state_nxt = CARGA;
      CARGA:   state_nxt = aborta ? OCIOSO : DESLOCA;
      DESLOCA: begin
        if (aborta)             state_nxt = OCIOSO;
        else if (cnt <= 3'd1)   state_nxt = FIM;
      end
      FIM:     state_nxt = OCIOSO;
      default: state_nxt = OCIOSO;
    endcase
  end

  // Outputs are decoded from the next state so that every port comes straight
  // from a flop yet still reflects the state of the cycle it appears in.
  always_comb begin
    out_nxt  = out_q;
    cnt_nxt  = cnt;
    modo_nxt = modo_q;

    if (inicia) begin
      modo_nxt          = modo;
      cnt_nxt           = (n_passos == 3'd0) ? CNT_MAX : n_passos;
      out_nxt.capturada = '0;
    end

    // collection continues on an aborted cycle so the partial word is kept
    if (state == DESLOCA) begin
      out_nxt.capturada = {out_q.capturada[5:0], saida_ultimoflip};
      if (cnt != 3'd0) cnt_nxt = cnt - 3'd1;
    end

    out_nxt.ch   = 2'b00;
    out_nxt.d    = 1'b0;
    out_nxt.busy = 1'b0;
    out_nxt.done = 1'b0;
    case (state_nxt)
      CARGA: begin
        // CARGA is entered only from the start edge, so dado is the latched word
        out_nxt.ch   = 2'b10;
        out_nxt.bits = dado;
        out_nxt.busy = 1'b1;
      end
      DESLOCA: begin
        out_nxt.ch   = {modo_q, 1'b1};
        out_nxt.d    = serial_in;
        out_nxt.busy = 1'b1;
      end
      FIM:     out_nxt.done = 1'b1;
      default: ;
    endcase
  end

  assign {ch1, ch0} = out_q.ch;
  assign bits       = out_q.bits;
  assign d          = out_q.d;
  assign busy       = out_q.busy;
  assign done       = out_q.done;
  assign capturada  = out_q.capturada;

endmodule

// File: tb/tb_controle_registrador_7bits.sv
// Bench for controle_registrador_7bits with a 7-bit universal register attached;
// a queue-of-phases reference model checks every output every cycle.
module tb_controle_registrador_7bits;
  localparam int PASSOS = 7;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       start = 1'b0, aborta = 1'b0, modo = 1'b0, serial_in = 1'b0;
  logic [2:0] n_passos = 3'd0;
  logic [6:0] dado = 7'd0;
  logic       saida_ultimoflip, ch1, ch0, d, busy, done;
  logic [6:0] bits, capturada;
  logic [6:0] q;
  int total = 0, bad = 0;

  controle_registrador_7bits #(.PASSOS_MAX(PASSOS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .aborta(aborta), .modo(modo),
    .n_passos(n_passos), .dado(dado), .serial_in(serial_in),
    .saida_ultimoflip(saida_ultimoflip), .ch1(ch1), .ch0(ch0), .bits(bits),
    .d(d), .busy(busy), .done(done), .capturada(capturada)
  );

  always #5 clk = ~clk;

  // the controlled register: 00 hold, 01 shift, 10 load, 11 rotate
  assign saida_ultimoflip = q[6];
  always @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else case ({ch1, ch0})
      2'b01:   q <= {q[5:0], d};
      2'b10:   q <= bits;
      2'b11:   q <= {q[5:0], q[6]};
      default: ;
    endcase

  // reference model: phase of the current cycle plus queue of upcoming phases
  // (0 idle, 1 load, 2 shift, 3 finish)
  int         ph;
  int         phq[$];
  logic [6:0] m_dado, m_bits, m_cap;
  logic       m_modo, m_d;

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    ph = 0; phq.delete();
    m_dado = '0; m_bits = '0; m_cap = '0; m_modo = 1'b0; m_d = 1'b0;
  endtask

  task automatic model_edge();
    int n;
    if (ph == 2) m_cap = {m_cap[5:0], saida_ultimoflip};
    if ((ph == 1 || ph == 2) && aborta) phq.delete();
    else if (ph == 0 && start && !aborta) begin
      n = (n_passos == 3'd0) ? PASSOS : int'(n_passos);
      m_dado = dado; m_modo = modo; m_cap = '0;
      phq.push_back(1);
      repeat (n) phq.push_back(2);
      phq.push_back(3);
    end
    ph = (phq.size() > 0) ? phq.pop_front() : 0;
    if (ph == 1) m_bits = m_dado;
    m_d = (ph == 2) ? serial_in : 1'b0;
  endtask

  task automatic check_outputs();
    int ech;
    ech = (ph == 1) ? 2 : (ph == 2) ? (m_modo ? 3 : 1) : 0;
    chk("ch", int'({ch1, ch0}), ech);
    chk("busy", int'(busy), (ph == 1 || ph == 2) ? 1 : 0);
    chk("done", int'(done), (ph == 3) ? 1 : 0);
    chk("bits", int'(bits), int'(m_bits));
    chk("d", int'(d), int'(m_d));
    chk("capturada", int'(capturada), int'(m_cap));
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  typedef struct {
    logic [6:0] dado;
    logic [2:0] n;
    logic       modo;
    int         lat;
    int         nsh;
    logic [6:0] cap;
    logic [6:0] qf;
  } vec_t;
  vec_t tab[5];

  task automatic run_op(int i);
    int cyc, nsh;
    dado = tab[i].dado; n_passos = tab[i].n; modo = tab[i].modo;
    serial_in = 1'b0; aborta = 1'b0; start = 1'b1;
    step();
    // operands must stay latched while the inputs wander
    start = 1'b0; dado = ~tab[i].dado; modo = ~tab[i].modo; n_passos = 3'd2;
    cyc = 1; nsh = 0;
    while (!done && cyc < 24) begin
      if ({ch1, ch0} == (tab[i].modo ? 2'b11 : 2'b01)) nsh++;
      step();
      cyc++;
    end
    chk($sformatf("latency[%0d]", i), cyc, tab[i].lat);
    chk($sformatf("shift_cycles[%0d]", i), nsh, tab[i].nsh);
    chk($sformatf("cap_final[%0d]", i), int'(capturada), int'(tab[i].cap));
    chk($sformatf("reg_final[%0d]", i), int'(q), int'(tab[i].qf));
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cyc;
    logic seen;
    tab[0] = '{7'b1011001, 3'd7, 1'b0, 9, 7, 7'b1011001, 7'b0000000};
    tab[1] = '{7'b1011001, 3'd3, 1'b0, 5, 3, 7'b0000101, 7'b1001000};
    tab[2] = '{7'b1011001, 3'd0, 1'b1, 9, 7, 7'b1011001, 7'b1011001};
    tab[3] = '{7'b1000000, 3'd1, 1'b0, 3, 1, 7'b0000001, 7'b0000000};
    tab[4] = '{7'b0110011, 3'd5, 1'b1, 7, 5, 7'b0001100, 7'b1101100};

    model_reset();
    #12;
    check_outputs();
    chk("reset_reg", int'(q), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) run_op(i);

    // abort in the second shift cycle
    dado = 7'b1011001; n_passos = 3'd7; modo = 1'b0; start = 1'b1;
    step(); start = 1'b0;
    step(); step();
    aborta = 1'b1; step(); aborta = 1'b0;
    chk("abort_ch", int'({ch1, ch0}), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_cap", int'(capturada), 7'b0000010);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin step(); if (done) seen = 1'b1; end
    chk("abort_no_done", int'(seen), 0);

    // start held high through busy and finish, then start+aborta together
    dado = 7'b1011001; n_passos = 3'd3; modo = 1'b0; start = 1'b1;
    step();
    dado = 7'b0000000; n_passos = 3'd2; modo = 1'b1;
    cyc = 0;
    while (!done && cyc < 20) begin step(); cyc++; end
    chk("busy_start_latency", cyc, 4);
    chk("busy_start_cap", int'(capturada), 7'b0000101);
    step();
    start = 1'b0;
    chk("start_in_fim_ignored", int'(busy), 0);
    start = 1'b1; aborta = 1'b1; step();
    chk("start_abort_busy0", int'(busy), 0);
    start = 1'b0; aborta = 1'b0; step();
    chk("start_abort_busy1", int'(busy), 0);

    // asynchronous reset between edges during shifting
    dado = 7'b1011001; n_passos = 3'd7; modo = 1'b0; start = 1'b1;
    step(); start = 1'b0;
    step(); step();
    #3 rst_n = 1'b0;
    #1;
    chk("arst_ch", int'({ch1, ch0}), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_done", int'(done), 0);
    chk("arst_bits", int'(bits), 0);
    chk("arst_d", int'(d), 0);
    chk("arst_cap", int'(capturada), 0);
    model_reset();
    #2 rst_n = 1'b1;
    step();
    run_op(1);

    // randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      start     = ($urandom_range(0, 2) == 0);
      aborta    = ($urandom_range(0, 11) == 0);
      modo      = 1'($urandom);
      n_passos  = 3'($urandom);
      dado      = 7'($urandom);
      serial_in = 1'($urandom);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/controle_registrador_7bits.md
CONTROLE_REGISTRADOR_7BITS -- requirements
Module: controle_registrador_7bits

Interface
REQ-001 SHALL have parameter PASSOS_MAX, default 7, the maximum shift count per operation and the count used when n_passos = 0.
REQ-002 SHALL have port clk, input, 1 bit: single system clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port start, input, 1 bit: request one load+shift operation; sampled only in OCIOSO.
REQ-005 SHALL have port aborta, input, 1 bit: cancel the current operation.
REQ-006 SHALL have port modo, input, 1 bit: 0 = shift, 1 = rotate; latched at start.
REQ-007 SHALL have port n_passos, input, 3 bits: shift count 1..7 (0 means PASSOS_MAX); latched at start.
REQ-008 SHALL have port dado, input, 7 bits: word to load; latched at start.
REQ-009 SHALL have port serial_in, input, 1 bit: serial bit forwarded to the register while shifting.
REQ-010 SHALL have port saida_ultimoflip, input, 1 bit: last-stage output of the 7-bit register.
REQ-011 SHALL have ports ch1 and ch0, outputs, 1 bit each: register mode (00 hold, 01 shift, 10 parallel load, 11 rotate).
REQ-012 SHALL have port bits, output, 7 bits: parallel word to the register.
REQ-013 SHALL have port d, output, 1 bit: serial input to the register.
REQ-014 SHALL have ports busy and done, outputs, 1 bit each: operation in progress, and a one-cycle completion pulse.
REQ-015 SHALL have port capturada, output, 7 bits: bits collected from saida_ultimoflip.

Function
REQ-016 SHALL implement an FSM with states OCIOSO, CARGA, DESLOCA and FIM; all outputs SHALL be registered.
REQ-017 OCIOSO: ch=00, busy=0; on start=1 and aborta=0, latch dado, modo and count (n_passos, with 0 replaced by PASSOS_MAX), clear capturada, then go to CARGA.
REQ-018 CARGA lasts exactly one cycle: ch=10, bits=latched dado, busy=1; next state is DESLOCA.
REQ-019 DESLOCA lasts exactly count cycles: ch=01 (modo=0) or 11 (modo=1), busy=1, d=serial_in.
REQ-020 In each DESLOCA cycle, capturada SHALL update as {capturada[5:0], saida_ultimoflip}.
REQ-021 After the last DESLOCA cycle the FSM SHALL enter FIM.
REQ-022 FIM lasts one cycle: ch=00, done=1, busy=0; next state is OCIOSO.
REQ-023 Latency: with start sampled at edge k, CARGA occupies cycle k+1, DESLOCA occupies cycles k+2..k+1+N, and done=1 in cycle k+2+N.
REQ-024 The shift counter SHALL be 3 bits, decrement once per DESLOCA cycle, never wrap, and leave DESLOCA when it reaches 1.
REQ-025 start while busy=1 or during FIM SHALL be ignored; the latched operands SHALL NOT change.
REQ-026 aborta=1 in CARGA or DESLOCA: the next state SHALL be OCIOSO with ch=00, busy=0 and done never asserted; capturada SHALL keep the bits collected so far.
REQ-027 start and aborta both 1 in OCIOSO: aborta SHALL win and the FSM SHALL stay in OCIOSO.
REQ-028 aborta in FIM SHALL have no effect; done SHALL still pulse.
REQ-029 bits SHALL hold its last driven value outside CARGA; d SHALL be 0 outside DESLOCA.

Reset
REQ-030 rst_n=0 SHALL immediately, without waiting for a clock edge, force state=OCIOSO, ch1=ch0=0, bits=0, d=0, busy=0, done=0, capturada=0 and counter=0.
REQ-031 Reset asserted mid-operation SHALL discard the operation; after release the FSM SHALL wait for a new start.
REQ-032 The first edge after rst_n rises SHALL be treated as a normal OCIOSO cycle.

Verification
REQ-033 Run with the 7-bit register attached: dado=1011001, n_passos=7, modo=0 -> ch sequence 10, then 01 x7, then 00; done exactly 9 cycles after start; capturada=1011001.
REQ-034 dado=1011001, n_passos=3 -> 3 cycles of ch=01; capturada=0000101; done at start+5.
REQ-035 n_passos=0, modo=1 -> 7 cycles of ch=11; capturada=1011001; the register again holds 1011001 after FIM.
REQ-036 aborta=1 during the 2nd DESLOCA cycle -> ch=00 and busy=0 on the next cycle; done never asserted; capturada holds 2 collected bits.
REQ-037 start pulsed while busy, then start and aborta together in OCIOSO -> no new operation is started and busy stays 0.
REQ-038 rst_n pulsed low asynchronously (between clock edges) during DESLOCA -> all outputs are 0 immediately; a following start completes normally.
